// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - in-order pipeline hazard/forwarding scoreboard
// Optional stall-cycle statistics counter built only when HAZ_STATS_EN is defined.
module pipe_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 4,
    parameter int RDY_ALU  = 2,
    parameter int RDY_LOAD = 3,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_dst_i,
    input  logic              id_regwrite_i,
    input  logic              id_load_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              bubble_o,
    output logic [SEL_W-1:0]  ex_fwd_a_o,
    output logic [SEL_W-1:0]  ex_fwd_b_o,
    output logic              id_fwd_a_o,
    output logic              id_fwd_b_o,
    output logic [31:0]       stall_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic              load;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
    } entry_t;

    if (DEPTH < 3 || DEPTH > 8 || RDY_ALU < 2 || RDY_ALU > DEPTH ||
        RDY_LOAD < RDY_ALU || RDY_LOAD > DEPTH || SEL_W < $clog2(DEPTH + 1)) begin : g_param_check
        $error("pipe_hazard_scoreboard: illegal parameter set");
    end

    // sb[1] is the ID/EX register, sb[DEPTH] the final write-back register
    entry_t sb [1:DEPTH];
    entry_t id_entry;

    logic haz_a;
    logic haz_b;
    logic found_a;
    logic found_b;
    logic hazard;
    logic issue;

    function automatic logic produces(input entry_t e, input logic [REG_AW-1:0] opnd,
                                      input logic use_op);
        return e.valid && e.regwrite && (e.dst != '0) && (e.dst == opnd) && use_op;
    endfunction

    function automatic int rdy(input logic load);
        return load ? RDY_LOAD : RDY_ALU;
    endfunction

    assign id_entry = '{valid: 1'b1, dst: id_dst_i, regwrite: id_regwrite_i, load: id_load_i,
                        rs: id_rs_i, rt: id_rt_i, use_rs: id_use_rs_i, use_rt: id_use_rt_i};

    // Only the youngest producer matters; an older one is shadowed by it.
    always_comb begin
        haz_a   = 1'b0;
        haz_b   = 1'b0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int s = 1; s <= DEPTH; s++) begin
            if (!found_a && produces(sb[s], id_rs_i, id_use_rs_i)) begin
                found_a = 1'b1;
                haz_a   = (s + 1 < rdy(sb[s].load));
            end
            if (!found_b && produces(sb[s], id_rt_i, id_use_rt_i)) begin
                found_b = 1'b1;
                haz_b   = (s + 1 < rdy(sb[s].load));
            end
        end
    end

    assign hazard = id_valid_i && (haz_a || haz_b);
    assign issue  = id_valid_i && !hazard && !flush_i;

    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        bubble_o     = 1'b0;
        if (!rst_i) begin
            pc_write_o = 1'b1;
        end else if (mem_stall_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (flush_i) begin
            bubble_o = 1'b1;
        end else if (hazard) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            bubble_o     = 1'b1;
        end
    end

    // Scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        ex_fwd_a_o = '0;
        ex_fwd_b_o = '0;
        for (int k = DEPTH; k >= 2; k--) begin
            if (sb[1].valid && produces(sb[k], sb[1].rs, sb[1].use_rs)) begin
                ex_fwd_a_o = SEL_W'(k);
            end
            if (sb[1].valid && produces(sb[k], sb[1].rt, sb[1].use_rt)) begin
                ex_fwd_b_o = SEL_W'(k);
            end
        end
    end

    assign id_fwd_a_o = produces(sb[DEPTH], id_rs_i, id_use_rs_i);
    assign id_fwd_b_o = produces(sb[DEPTH], id_rt_i, id_use_rt_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 1; k <= DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else if (!mem_stall_i) begin
            sb[1] <= issue ? id_entry : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (!pc_write_o && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - self-checking bench for pipe_hazard_scoreboard
module tb_pipe_hazard_scoreboard;

    localparam int AW       = 5;
    localparam int DEPTH    = 4;
    localparam int RDY_ALU  = 2;
    localparam int RDY_LOAD = 3;
    localparam int SW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [AW-1:0] id_dst;
    logic          id_regwrite;
    logic          id_load;
    logic          mem_stall;
    logic          flush;
    logic          pc_write;
    logic          ifid_write;
    logic          bubble;
    logic [SW-1:0] ex_fwd_a;
    logic [SW-1:0] ex_fwd_b;
    logic          id_fwd_a;
    logic          id_fwd_b;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(
        .REG_AW(AW), .DEPTH(DEPTH), .RDY_ALU(RDY_ALU), .RDY_LOAD(RDY_LOAD), .SEL_W(SW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dst_i(id_dst),
        .id_regwrite_i(id_regwrite), .id_load_i(id_load), .mem_stall_i(mem_stall),
        .flush_i(flush), .pc_write_o(pc_write), .ifid_write_o(ifid_write), .bubble_o(bubble),
        .ex_fwd_a_o(ex_fwd_a), .ex_fwd_b_o(ex_fwd_b), .id_fwd_a_o(id_fwd_a),
        .id_fwd_b_o(id_fwd_b), .stall_cnt_o(stall_cnt)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          urs;
        logic          urt;
        logic [AW-1:0] dst;
        logic          rw;
        logic          ld;
        logic          st;
        logic          fl;
        logic [10:0]   exp;
    } vec_t;

    // Reference model: in-flight instructions only, youngest first, tagged by stage age.
    typedef struct {
        logic [AW-1:0] dst;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        bit            rw;
        bit            ld;
        bit            urs;
        bit            urt;
        int            age;
    } inst_t;

    inst_t       pipe[$];
    logic [31:0] exp_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [10:0] ev(input bit pcw, input bit ifw, input bit bub,
                                       input int exa, input int exb, input bit ida, input bit idb);
        return {pcw, ifw, bub, SW'(exa), SW'(exb), ida, idb};
    endfunction

    function automatic vec_t mk(input bit v, input int rs, input int rt, input bit urs,
                                input bit urt, input int dst, input bit rw, input bit ld,
                                input bit st, input bit fl, input logic [10:0] exp);
        vec_t x;
        x.v = v; x.rs = AW'(rs); x.rt = AW'(rt); x.urs = urs; x.urt = urt;
        x.dst = AW'(dst); x.rw = rw; x.ld = ld; x.st = st; x.fl = fl; x.exp = exp;
        return x;
    endfunction

    function automatic bit writes(input inst_t p, input logic [AW-1:0] r);
        return p.rw && p.dst != 0 && p.dst == r;
    endfunction

    function automatic bit m_hazard(input logic [AW-1:0] r, input bit u);
        if (!u) return 1'b0;
        foreach (pipe[i]) begin
            if (writes(pipe[i], r)) return (pipe[i].age + 1 < (pipe[i].ld ? RDY_LOAD : RDY_ALU));
        end
        return 1'b0;
    endfunction

    function automatic int m_exfwd(input bit side_a);
        int idx = -1;
        logic [AW-1:0] r;
        bit u;
        foreach (pipe[i]) if (pipe[i].age == 1) idx = i;
        if (idx < 0) return 0;
        r = side_a ? pipe[idx].rs : pipe[idx].rt;
        u = side_a ? pipe[idx].urs : pipe[idx].urt;
        if (!u) return 0;
        foreach (pipe[i]) begin
            if (pipe[i].age >= 2 && writes(pipe[i], r)) return pipe[i].age;
        end
        return 0;
    endfunction

    function automatic bit m_idfwd(input logic [AW-1:0] r, input bit u);
        foreach (pipe[i]) if (u && pipe[i].age == DEPTH && writes(pipe[i], r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_haz_now();
        return id_valid && (m_hazard(id_rs, id_use_rs) || m_hazard(id_rt, id_use_rt));
    endfunction

    function automatic logic [10:0] model_vec();
        bit pcw = 1, ifw = 1, bub = 0;
        if (mem_stall) begin
            pcw = 0; ifw = 0;
        end else if (flush) begin
            bub = 1;
        end else if (m_haz_now()) begin
            pcw = 0; ifw = 0; bub = 1;
        end
        return ev(pcw, ifw, bub, m_exfwd(1'b1), m_exfwd(1'b0),
                  m_idfwd(id_rs, id_use_rs), m_idfwd(id_rt, id_use_rt));
    endfunction

    function automatic logic [10:0] out_vec();
        return {pc_write, ifid_write, bubble, ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs; id_use_rt = x.urt;
        id_dst = x.dst; id_regwrite = x.rw; id_load = x.ld; mem_stall = x.st; flush = x.fl;
    endtask

    task automatic tick();
        logic [10:0] e;
        bit haz;
        inst_t n;
        e   = model_vec();
        haz = m_haz_now();
`ifdef HAZ_STATS_EN
        if (!e[10] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
`endif
        if (!mem_stall) begin
            foreach (pipe[i]) pipe[i].age++;
            while (pipe.size() > 0 && pipe[pipe.size()-1].age > DEPTH) void'(pipe.pop_back());
            if (id_valid && !haz && !flush) begin
                n.dst = id_dst; n.rs = id_rs; n.rt = id_rt; n.rw = id_regwrite;
                n.ld = id_load; n.urs = id_use_rs; n.urt = id_use_rt; n.age = 1;
                pipe.push_front(n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("reset_ctl", out_vec(), ev(1, 1, 0, 0, 0, 0, 0));
        chk("reset_cnt", stall_cnt, 32'd0);
        pipe.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run(input vec_t x, input string name);
        drive(x);
        #1;
        chk(name, out_vec(), x.exp);
        tick();
    endtask

    vec_t tbl[$];
    vec_t nrm;
    vec_t rv;

    initial begin
        logic [10:0] norm;
        norm = ev(1, 1, 0, 0, 0, 0, 0);
        nrm  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, norm);
        drive(nrm);

        //                v  rs rt us ut dst rw ld st fl  expected
        tbl.push_back(mk(1,  1, 0, 1, 0, 2, 1, 1, 0, 0, norm));                 // lw r2
        tbl.push_back(mk(1,  2, 4, 1, 1, 3, 1, 0, 0, 0, ev(0,1'b0,1,0,0,0,0))); // load-use
        tbl.push_back(mk(1,  2, 4, 1, 1, 3, 1, 0, 0, 0, norm));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, ev(1,1,0,3,0,0,0)));
        tbl.push_back(mk(1,  2, 0, 1, 0, 0, 0, 0, 0, 0, ev(1,1,0,0,0,1,0)));    // wb bypass
        tbl.push_back(mk(1,  9,10, 1, 1, 1, 1, 0, 0, 0, norm));                 // add r1
        tbl.push_back(mk(1,  1, 1, 1, 1, 5, 1, 0, 0, 0, norm));                 // sub r5,r1,r1
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, ev(1,1,0,2,2,0,0)));
        tbl.push_back(mk(1, 11,12, 1, 1, 1, 1, 0, 0, 0, norm));                 // add r1
        tbl.push_back(mk(1, 13, 0, 1, 0, 1, 1, 0, 0, 0, norm));                 // add r1
        tbl.push_back(mk(1,  1,14, 1, 1, 6, 1, 0, 0, 0, norm));                 // or r6,r1
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, ev(1,1,0,2,0,0,0)));    // youngest
        tbl.push_back(mk(1,  1, 0, 1, 1, 0, 0, 0, 0, 0, ev(1,1,0,0,0,1,0)));
        tbl.push_back(mk(1, 15, 0, 1, 0, 0, 1, 0, 0, 0, ev(1,1,0,4,0,0,0)));    // add r0
        tbl.push_back(mk(1,  0, 0, 1, 1, 0, 0, 0, 0, 0, norm));
        tbl.push_back(nrm);
        tbl.push_back(nrm);
        tbl.push_back(mk(1,  0, 0, 1, 1, 0, 0, 0, 0, 0, norm));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

        // data-memory wait during a load-use hazard
        do_reset();
        run(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, norm), "ms_lw");
        for (int i = 0; i < 3; i++)
            run(mk(1, 2, 4, 1, 1, 3, 1, 0, 1, 0, ev(0, 0, 0, 0, 0, 0, 0)), $sformatf("ms_frz%0d", i));
        run(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, ev(0, 0, 1, 0, 0, 0, 0)), "ms_haz");
        run(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, norm), "ms_issue");
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(1, 1, 0, 3, 0, 0, 0)), "ms_fwd");

        // flush overrides a pending load-use hazard
        do_reset();
        run(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, norm), "fl_lw");
        run(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 1, ev(1, 1, 1, 0, 0, 0, 0)), "fl_flush");
        run(nrm, "fl_empty");
        run(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, norm), "fl_issue");
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(1, 1, 0, 4, 0, 0, 0)), "fl_fwd");

        // asynchronous reset in the middle of a hazard stall
        do_reset();
        run(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, norm), "rs_lw");
        drive(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, norm));
        #1;
        chk("rs_stall", out_vec(), ev(0, 0, 1, 0, 0, 0, 0));
        do_reset();

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rv = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, norm);
            drive(rv);
            #1;
            chk("rand", out_vec(), model_vec());
            chk("stall_cnt", stall_cnt, exp_cnt);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
